adc3wire_multi_master: RTL



---
 rtl/adc3wire_pkg.sv | 34 +++
 rtl/adc3wire_multi_master_if.sv | 35 +++
 rtl/adc3wire_bit_timer.sv | 35 +++
 rtl/adc3wire_multi_master.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/adc3wire_pkg.sv
// -----------------------------------------------------------------------------
// adc3wire_pkg
// Shared definitions for the ADC 3-wire serial configuration master:
//   - state_e       : engine FSM states
//   - preamble_word : frame preamble value (LSB set, all other bits clear)
//   - frame_w       : total serial frame width (preamble + address + data)
//   - ch_w          : command channel-select width, at least one bit
// -----------------------------------------------------------------------------
package adc3wire_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEAD  = 3'd1,
      ST_SHIFT = 3'd2,
      ST_TRAIL = 3'd3,
      ST_RESP  = 3'd4
   } state_e;

   // Wide enough for any preamble; callers truncate to their width.
   function automatic logic [63:0] preamble_word();
      return 64'd1;
   endfunction

   function automatic int unsigned frame_w(input int unsigned pre_w,
                                           input int unsigned addr_w,
                                           input int unsigned data_w);
      return pre_w + addr_w + data_w;
   endfunction

   function automatic int unsigned ch_w(input int unsigned num_ch);
      return (num_ch <= 1) ? 1 : $clog2(num_ch);
   endfunction

endpackage

// File: rtl/adc3wire_multi_master_if.sv
// -----------------------------------------------------------------------------
// adc3wire_multi_master_if
// Command/response handshake between the Wishbone register slave and the
// ADC 3-wire engine.
//   master modport : register slave side (issues commands, receives responses)
//   slave modport  : engine side
// Signals: cmd_valid/cmd_ready handshake, cmd_ch/cmd_rd/cmd_addr/cmd_data
// command fields, rsp_valid pulse with rsp_err/rsp_data, busy status.
// -----------------------------------------------------------------------------
interface adc3wire_multi_master_if #(
   parameter int unsigned CH_W   = 1,
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 16
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [CH_W-1:0]   cmd_ch;
   logic              cmd_rd;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_data;
   logic              rsp_valid;
   logic              rsp_err;
   logic [DATA_W-1:0] rsp_data;
   logic              busy;

   modport master (
      output cmd_valid, cmd_ch, cmd_rd, cmd_addr, cmd_data,
      input  cmd_ready, rsp_valid, rsp_err, rsp_data, busy
   );

   modport slave (
      input  cmd_valid, cmd_ch, cmd_rd, cmd_addr, cmd_data,
      output cmd_ready, rsp_valid, rsp_err, rsp_data, busy
   );
endinterface

// File: rtl/adc3wire_bit_timer.sv
// -----------------------------------------------------------------------------
// adc3wire_bit_timer
// Bit-period divider: a CLK_DIV_LOG2-bit counter that runs while enabled and
// is held at zero otherwise.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_en           : count enable (engine in LEAD/SHIFT/TRAIL)
//   o_sclk         : serial clock level (counter MSB)
//   o_rise         : serial clock 0->1 happens at the next clk edge
//   o_wrap         : last cycle of the bit period (counter all ones)
// -----------------------------------------------------------------------------
module adc3wire_bit_timer #(
   parameter int unsigned CLK_DIV_LOG2 = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   output logic o_sclk,
   output logic o_rise,
   output logic o_wrap
);
   localparam logic [CLK_DIV_LOG2-1:0] RISE_AT =
      CLK_DIV_LOG2'((1 << (CLK_DIV_LOG2 - 1)) - 1);

   logic [CLK_DIV_LOG2-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)  r_cnt <= '0;
      else if (i_en) r_cnt <= r_cnt + 1'b1;
      else           r_cnt <= '0;
   end

   assign o_sclk = r_cnt[CLK_DIV_LOG2-1];
   assign o_rise = i_en && (r_cnt == RISE_AT);
   assign o_wrap = i_en && (&r_cnt);
endmodule

// File: rtl/adc3wire_multi_master.sv
// -----------------------------------------------------------------------------
// adc3wire_multi_master
// Serial configuration master for NUM_CH ADC 3-wire ports sharing one shift
// engine. Each command selects a port and shifts {preamble, addr, data}
// MSB-first, framed by a strobe-high lead and trail bit period.
//   wb_clk_i, wb_rst_n_i : sole clock, asynchronous active-low reset
//   bus                  : command/response handshake (slave modport)
//   adc3wire_clk/data/strobe_n : per-port serial outputs
//   adc3wire_sdi         : per-port serial input (readback build only)
// Build option: define ADC3WIRE_READBACK_EN to enable read frames, which
// drive a zero data field and capture sdi into rsp_data.
// -----------------------------------------------------------------------------
module adc3wire_multi_master
   import adc3wire_pkg::*;
#(
   parameter int unsigned NUM_CH       = 2,
   parameter int unsigned ADDR_W       = 4,
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned PREAMBLE_W   = 12,
   parameter int unsigned CLK_DIV_LOG2 = 4
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_n_i,
   adc3wire_multi_master_if.slave bus,
   output logic [NUM_CH-1:0]     adc3wire_clk,
   output logic [NUM_CH-1:0]     adc3wire_data,
   output logic [NUM_CH-1:0]     adc3wire_strobe_n,
   input  logic [NUM_CH-1:0]     adc3wire_sdi
);
   localparam int unsigned CH_W    = ch_w(NUM_CH);
   localparam int unsigned FRAME_W = frame_w(PREAMBLE_W, ADDR_W, DATA_W);
   localparam int unsigned IDX_W   = $clog2(FRAME_W);
   localparam logic [PREAMBLE_W-1:0] PREAMBLE = PREAMBLE_W'(preamble_word());
   localparam logic [IDX_W-1:0] LAST_IDX       = IDX_W'(FRAME_W - 1);
   localparam logic [IDX_W-1:0] FIRST_DATA_IDX = IDX_W'(FRAME_W - DATA_W);

   state_e              r_state;
   logic [CH_W-1:0]     r_ch;
   logic [FRAME_W-1:0]  r_shift;
   logic [IDX_W-1:0]    r_idx;
   logic                r_rsp_valid;
   logic                r_rsp_err;
   logic [DATA_W-1:0]   r_rsp_data;

   logic                w_active, w_sclk, w_rise, w_wrap, w_accept, w_ch_ok, w_rd;
   logic [DATA_W-1:0]   w_wdata, w_rdata_next;

   assign w_accept = bus.cmd_valid && (r_state == ST_IDLE);
   // Compare at 32 bits: CH_W may be too narrow to hold NUM_CH itself.
   assign w_ch_ok  = (32'(bus.cmd_ch) < NUM_CH);
   assign w_wdata  = w_rd ? '0 : bus.cmd_data;
   assign w_active = (r_state == ST_LEAD) || (r_state == ST_SHIFT) || (r_state == ST_TRAIL);

   adc3wire_bit_timer #(.CLK_DIV_LOG2(CLK_DIV_LOG2)) u_bit_timer (
      .i_clk   (wb_clk_i),
      .i_rst_n (wb_rst_n_i),
      .i_en    (w_active),
      .o_sclk  (w_sclk),
      .o_rise  (w_rise),
      .o_wrap  (w_wrap)
   );

`ifdef ADC3WIRE_READBACK_EN
   logic              r_rd;
   logic [DATA_W-1:0] r_rdata;
   logic              w_sdi_bit;

   assign w_rd = bus.cmd_rd;

   always_comb begin
      w_sdi_bit = 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++)
         if (r_ch == CH_W'(i)) w_sdi_bit = adc3wire_sdi[i];
   end

   // The data field occupies the last DATA_W bits; sample each on its rising edge.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         r_rd    <= 1'b0;
         r_rdata <= '0;
      end else if (w_accept) begin
         r_rd    <= w_rd;
         r_rdata <= '0;
      end else if ((r_state == ST_SHIFT) && w_rise && (r_idx >= FIRST_DATA_IDX)) begin
         r_rdata <= DATA_W'({r_rdata, w_sdi_bit});
      end
   end

   assign w_rdata_next = r_rd ? r_rdata : '0;
`else
   logic w_unused;
   assign w_rd         = 1'b0;
   assign w_rdata_next = '0;
   assign w_unused     = ^{bus.cmd_rd, adc3wire_sdi, w_rise};
`endif

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         r_state     <= ST_IDLE;
         r_ch        <= '0;
         r_shift     <= '0;
         r_idx       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_data  <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            ST_IDLE: if (w_accept) begin
               r_ch    <= bus.cmd_ch;
               r_shift <= {PREAMBLE, bus.cmd_addr, w_wdata};
               r_idx   <= '0;
               if (w_ch_ok) begin
                  r_state <= ST_LEAD;
               end else begin
                  // Bad channel: respond immediately, no pin activity.
                  r_state     <= ST_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b1;
                  r_rsp_data  <= '0;
               end
            end
            ST_LEAD: if (w_wrap) r_state <= ST_SHIFT;
            ST_SHIFT: if (w_wrap) begin
               r_shift <= r_shift << 1;
               r_idx   <= r_idx + 1'b1;
               if (r_idx == LAST_IDX) r_state <= ST_TRAIL;
            end
            ST_TRAIL: if (w_wrap) begin
               r_state     <= ST_RESP;
               r_rsp_valid <= 1'b1;
               r_rsp_err   <= 1'b0;
               r_rsp_data  <= w_rdata_next;
            end
            ST_RESP: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Port demux; decoded from state so reset idles the pins immediately.
   always_comb begin
      adc3wire_clk      = '0;
      adc3wire_data     = '0;
      adc3wire_strobe_n = '1;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (r_ch == CH_W'(i)) begin
            adc3wire_clk[i]      = w_sclk;
            adc3wire_data[i]     = (r_state == ST_SHIFT) && r_shift[FRAME_W-1];
            adc3wire_strobe_n[i] = (r_state != ST_SHIFT);
         end
      end
   end

   assign bus.cmd_ready = (r_state == ST_IDLE);
   assign bus.busy      = (r_state != ST_IDLE);
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_err   = r_rsp_err;
   assign bus.rsp_data  = r_rsp_data;
endmodule
